// File: rtl/axis_adc_block_averager.sv
// Boxcar decimator for a free-running ADC stream: emits the mean of every 2^LOG2_N samples.
// Define AXIS_AVG_ROUND_EN for round-half-up; otherwise the mean is truncated.
module axis_adc_block_averager #(
  parameter int unsigned LOG2_N    = 4,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] overrun_count
);

  localparam int unsigned AccW = 16 + LOG2_N;
  localparam int unsigned CntW = (LOG2_N > 0) ? LOG2_N : 1;
  // With LOG2_N == 0 the counter is pinned at 0, so every accept completes a block.
  localparam logic [CntW-1:0] CntLast   = CntW'((2 ** LOG2_N) - 1);
  localparam logic [15:0]     FrameLast = 16'(FRAME_LEN - 1);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic            in_rdy_q;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     frame_q, frame_d;
  logic [15:0]     tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic [15:0]     ovr_q, ovr_d;

  logic            accept;
  logic            complete;
  logic            load;
  logic [AccW-1:0] sum;
  logic [AccW-1:0] sum_r;
  logic [15:0]     result;

  assign accept   = s_axis_tvalid & in_rdy_q;
  assign complete = accept & (cnt_q == CntLast);
  assign sum      = acc_q + AccW'(s_axis_tdata);

`ifdef AXIS_AVG_ROUND_EN
  // Max sum is 2^AccW - 2^LOG2_N, so adding half an LSB cannot overflow.
  localparam logic [AccW-1:0] Bias = AccW'((2 ** LOG2_N) / 2);
  assign sum_r = sum + Bias;
`else
  assign sum_r = sum;
`endif

  assign result = sum_r[AccW-1:LOG2_N];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d = complete ? '0 : sum;
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (complete) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (complete) begin
          if (m_axis_tready) begin
            load = 1'b1;
          end else if (ovr_q != 16'hFFFF) begin
            ovr_d = ovr_q + 16'd1;
          end
        end else if (m_axis_tready) begin
          state_d = StEmpty;
        end
      end
    endcase
    // Only delivered results advance the frame position; drops leave it alone.
    if (load) begin
      tdata_d = result;
      tlast_d = (frame_q == FrameLast);
      frame_d = (frame_q == FrameLast) ? 16'd0 : frame_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      in_rdy_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      frame_q  <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= 1'b1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      ovr_q    <= ovr_d;
    end
  end

  assign s_axis_tready = in_rdy_q;
  assign m_axis_tvalid = (state_q == StFull);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_axis_adc_block_averager.sv
// Directed bench: four averager instances (LOG2_N = 2, 4, 1, 0) share one stimulus stream;
// each step targets one instance and checks it against hand-computed values.
module tb_axis_adc_block_averager;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sd;
  logic        sv;
  logic        mr;

  logic        tr2, v2, l2;
  logic [15:0] d2, o2;
  logic        tr4, v4, l4;
  logic [15:0] d4, o4;
  logic        tr1, v1, l1;
  logic [15:0] d1, o1;
  logic        tr0, v0, l0;
  logic [15:0] d0, o0;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef AXIS_AVG_ROUND_EN
  localparam logic [15:0] ExpMean1234 = 16'd3;
`else
  localparam logic [15:0] ExpMean1234 = 16'd2;
`endif

  always #5 clk = ~clk;

  axis_adc_block_averager #(.LOG2_N(2), .FRAME_LEN(256)) u_n2 (
    .clk(clk), .reset(reset), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tready(tr2),
    .m_axis_tdata(d2), .m_axis_tvalid(v2), .m_axis_tready(mr), .m_axis_tlast(l2),
    .overrun_count(o2)
  );
  axis_adc_block_averager #(.LOG2_N(4), .FRAME_LEN(256)) u_n4 (
    .clk(clk), .reset(reset), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tready(tr4),
    .m_axis_tdata(d4), .m_axis_tvalid(v4), .m_axis_tready(mr), .m_axis_tlast(l4),
    .overrun_count(o4)
  );
  axis_adc_block_averager #(.LOG2_N(1), .FRAME_LEN(256)) u_n1 (
    .clk(clk), .reset(reset), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tready(tr1),
    .m_axis_tdata(d1), .m_axis_tvalid(v1), .m_axis_tready(mr), .m_axis_tlast(l1),
    .overrun_count(o1)
  );
  axis_adc_block_averager #(.LOG2_N(0), .FRAME_LEN(4)) u_n0 (
    .clk(clk), .reset(reset), .s_axis_tdata(sd), .s_axis_tvalid(sv), .s_axis_tready(tr0),
    .m_axis_tdata(d0), .m_axis_tvalid(v0), .m_axis_tready(mr), .m_axis_tlast(l0),
    .overrun_count(o0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sv    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic feed(input logic [15:0] d);
    sv = 1'b1;
    sd = d;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    sv    = 1'b0;
    sd    = 16'd0;
    mr    = 1'b1;
    tick();
    chk("rst_tready", 16'(tr2), 16'd0);
    chk("rst_tvalid", 16'(v2), 16'd0);
    chk("rst_tdata", d2, 16'd0);
    chk("rst_tlast", 16'(l2), 16'd0);
    chk("rst_ovr", o2, 16'd0);
    reset = 1'b0;
    tick();
    chk("tready_after_rst", 16'(tr2), 16'd1);

    // 1: LOG2_N=2, mean of 1..4, one cycle of latency
    feed(16'd1);
    feed(16'd2);
    feed(16'd3);
    chk("t1_early_valid", 16'(v2), 16'd0);
    feed(16'd4);
    chk("t1_valid", 16'(v2), 16'd1);
    chk("t1_data", d2, ExpMean1234);
    chk("t1_tlast", 16'(l2), 16'd0);
    sv = 1'b0;
    tick();
    chk("t1_drained", 16'(v2), 16'd0);

    // 2: LOG2_N=4, full-scale then zero blocks
    do_reset();
    for (int i = 0; i < 16; i++) feed(16'hFFFF);
    chk("t2_valid_a", 16'(v4), 16'd1);
    chk("t2_data_a", d4, 16'hFFFF);
    feed(16'h0000);
    chk("t2_gap", 16'(v4), 16'd0);
    for (int i = 1; i < 16; i++) feed(16'h0000);
    chk("t2_valid_b", 16'(v4), 16'd1);
    chk("t2_data_b", d4, 16'h0000);
    chk("t2_ovr", o4, 16'd0);

    // 3: LOG2_N=1, stalled output drops later blocks
    mr = 1'b0;
    do_reset();
    feed(16'd10);
    feed(16'd20);
    chk("t3_valid_1", 16'(v1), 16'd1);
    chk("t3_data_1", d1, 16'd15);
    feed(16'd30);
    feed(16'd40);
    chk("t3_ovr_1", o1, 16'd1);
    feed(16'd50);
    feed(16'd60);
    chk("t3_hold_valid", 16'(v1), 16'd1);
    chk("t3_hold_data", d1, 16'd15);
    chk("t3_ovr_2", o1, 16'd2);
    sv = 1'b0;
    mr = 1'b1;
    tick();
    chk("t3_drained", 16'(v1), 16'd0);
    chk("t3_ovr_kept", o1, 16'd2);

    // 4: LOG2_N=0 pass-through, FRAME_LEN=4
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      feed(16'(i * 16'h0111));
      chk("t4_valid", 16'(v0), 16'd1);
      chk("t4_data", d0, 16'(i * 16'h0111));
      chk("t4_tlast", 16'(l0), (i % 4 == 0) ? 16'd1 : 16'd0);
    end
    sv = 1'b0;
    tick();
    chk("t4_drained", 16'(v0), 16'd0);

    // 5: reset mid-block discards the partial sum
    do_reset();
    feed(16'd100);
    feed(16'd100);
    reset = 1'b1;
    sv    = 1'b0;
    tick();
    chk("t5_tready", 16'(tr2), 16'd0);
    chk("t5_tvalid", 16'(v2), 16'd0);
    chk("t5_tdata", d2, 16'd0);
    chk("t5_tlast", 16'(l2), 16'd0);
    chk("t5_ovr", o2, 16'd0);
    reset = 1'b0;
    tick();
    feed(16'd4);
    feed(16'd4);
    chk("t5_no_early", 16'(v2), 16'd0);
    feed(16'd4);
    feed(16'd4);
    chk("t5_valid", 16'(v2), 16'd1);
    chk("t5_data", d2, 16'd4);

    // 6: ready rises on the cycle a new block completes
    mr = 1'b0;
    do_reset();
    feed(16'd7);
    feed(16'd9);
    chk("t6_full", d1, 16'd8);
    feed(16'd11);
    chk("t6_hold", d1, 16'd8);
    mr = 1'b1;
    feed(16'd13);
    chk("t6_valid", 16'(v1), 16'd1);
    chk("t6_data", d1, 16'd12);
    chk("t6_ovr", o1, 16'd0);
    sv = 1'b0;
    tick();
    chk("t6_drained", 16'(v1), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_adc_block_averager.md
Name: axis_adc_block_averager

Overview:
- AXI-Stream boxcar decimator placed directly downstream of the MAX1119x ADC AXIS master.
- Accumulates 2^LOG2_N consecutive 16-bit samples and emits one 16-bit mean per block.
- Marks every FRAME_LEN-th output with m_axis_tlast so the DMA/FIFO stage downstream can packetise.
- The ADC is free-running and does not honour backpressure, so the input is always accepted. Results that cannot be delivered are dropped and counted.

Parameters:
- LOG2_N, 4, log2 of samples per block; legal 0..8 (0 = pass-through with 1-cycle latency).
- FRAME_LEN, 256, outputs per frame; m_axis_tlast on the last one; legal 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  16  ADC sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  16  block mean.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last output of frame.
- overrun_count  out  16  number of dropped results, saturating.

Behaviour:
- Reset values (reset sampled high at a clk edge):
  - s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0; overrun_count=0.
  - Accumulator=0, sample counter=0, frame counter=0.
  - Reset mid-block discards the partial sum entirely.
- s_axis_tready is registered: 1 on every cycle after reset deasserts, and never depends on m_axis_tready.
- Accept: s_axis_tvalid && s_axis_tready.
- Each accept adds the zero-extended sample to a (16+LOG2_N)-bit accumulator and increments the sample counter (LOG2_N bits, wraps).
- Block completion = accept while sample counter == 2^LOG2_N-1. On that same clk edge:
  - sum = acc + sample; result = sum >> LOG2_N (truncate).
  - Accumulator and counter clear to 0; no sample is lost at the boundary.
  - The result reaches the output register the cycle after the last accept (latency 1 clk).
- Output register states: EMPTY (tvalid=0) and FULL (tvalid=1). Transitions:
  - EMPTY + completion -> FULL; load tdata and tlast.
  - FULL + m_axis_tready && !completion -> EMPTY.
  - FULL + m_axis_tready && completion -> FULL with the new result (back-to-back, no bubble, no overrun).
  - FULL + !m_axis_tready && completion -> new result dropped. tdata, tvalid and tlast hold unchanged. overrun_count += 1, saturating at 0xFFFF.
- tdata and tlast are stable while tvalid=1 and tready=0.
- Frame counter:
  - Advances only when a result is loaded into the output register; dropped results do not advance it.
  - tlast=1 on a loaded result when the counter == FRAME_LEN-1; the counter then wraps to 0.
  - FRAME_LEN=1 gives tlast on every output.
- Width rule: the max sum 0xFFFF·2^LOG2_N fits the accumulator; the result is always ≤ 0xFFFF, so no overflow path exists.

Optional Feature:
- Macro AXIS_AVG_ROUND_EN.
- Defined: round-half-up. result = (sum + 2^(LOG2_N-1)) >> LOG2_N. The adder is 16+LOG2_N bits, and the max result remains 0xFFFF. When LOG2_N=0 no bias is added.
- Undefined: pure truncation as above; no extra adder.
- Latency and handshake are identical in both builds.

Test Plan:
1. LOG2_N=2, m_axis_tready=1, feed 1,2,3,4 on consecutive cycles -> one beat: tdata=2 (truncation build) or 3 (AXIS_AVG_ROUND_EN build). tvalid is high exactly on the cycle after the 4th accept.
2. LOG2_N=4, 16 beats of 0xFFFF, then 16 beats of 0x0000 -> outputs 0xFFFF then 0x0000; overrun_count=0.
3. LOG2_N=1, m_axis_tready=0, feed 6 samples (three blocks: 10,20 / 30,40 / 50,60) -> first result 15 held. The 2nd and 3rd are dropped, overrun_count=2. Raising tready transfers 15 once; tvalid then drops.
4. LOG2_N=0, FRAME_LEN=4, tready=1, feed 8 samples -> 8 outputs equal to the inputs, 1-cycle latency; tlast on outputs 4 and 8 only.
5. LOG2_N=2: feed 100,100, assert reset 1 cycle, then feed 4,4,4,4 -> single output 4; all outputs and overrun_count are 0 on the cycle after reset.
6. LOG2_N=1: hold the output FULL with tready=0, then assert tready on the same cycle a new block completes -> the old beat transfers, the new result is loaded next cycle, overrun_count unchanged.
